e_alu_stage: RTL

E_ALU_STAGE -- requirements
Module: e_alu_stage

---
 rtl/e_alu_stage_pkg.sv | 45 ++++
 rtl/e_alu.sv | 89 ++++++++
 rtl/e_alu_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/e_alu_stage_pkg.sv
// Shared ALU encodings and micro-op bundles for the execute ALU stage.
// Tag fields are sized to TAG_W; the stage narrows them to its parameters.
package e_alu_stage_pkg;

   localparam logic [2:0] GOP_ARITH = 3'd1;
   localparam logic [2:0] GOP_LOGIC = 3'd2;
   localparam logic [2:0] GOP_SHIFT = 3'd3;
   localparam logic [2:0] GOP_MISC  = 3'd4;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_SLTU = 3'd3;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;

   localparam logic [2:0] OP_LUI    = 3'd0;
   localparam logic [2:0] OP_PCADDU = 3'd1;

   localparam int unsigned TAG_W = 16;

   typedef struct packed {
      logic [31:0]      r0;
      logic [31:0]      r1;
      logic [31:0]      pc;
      logic [2:0]       grand_op;
      logic [2:0]       op;
      logic [TAG_W-1:0] rob_id;
      logic [TAG_W-1:0] preg;
   } uop_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] rob_id;
      logic [TAG_W-1:0] preg;
   } res_t;

endpackage

// File: rtl/e_alu.sv
// Combinational integer ALU placed between S1 and S2.
// Add, subtract and both compares share one 33-bit adder.
module e_alu
   import e_alu_stage_pkg::*;
(
   input  logic [2:0]  grand_op_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] r0_i,
   input  logic [31:0] r1_i,
   input  logic [31:0] pc_i,
   output logic [31:0] res_o
);

   logic        sub;
   logic [32:0] sum;
   logic        lt_s;
   logic        lt_u;
   logic [4:0]  shamt;
   logic [31:0] upper;
   logic [31:0] arith_r;
   logic [31:0] logic_r;
   logic [31:0] shift_r;
   logic [31:0] misc_r;

   assign sub = (op_i != OP_ADD);
   assign sum = {1'b0, r0_i}
              + {1'b0, r1_i ^ {32{sub}}}
              + 33'(sub);

   // no carry out of r0 + ~r1 + 1 means r0 < r1
   assign lt_u = !sum[32];
   assign lt_s = (r0_i[31] ^ r1_i[31]) ? r0_i[31] : sum[31];

   assign shamt = r1_i[4:0];
   assign upper = {r1_i[19:0], 12'h000};

   always_comb begin
      arith_r = '0;
      unique case (op_i)
         OP_ADD,
         OP_SUB:  arith_r = sum[31:0];
         OP_SLT:  arith_r = {31'd0, lt_s};
         OP_SLTU: arith_r = {31'd0, lt_u};
         default: arith_r = '0;
      endcase
   end

   always_comb begin
      logic_r = '0;
      unique case (op_i)
         OP_AND:  logic_r = r0_i & r1_i;
         OP_OR:   logic_r = r0_i | r1_i;
         OP_XOR:  logic_r = r0_i ^ r1_i;
         OP_NOR:  logic_r = ~(r0_i | r1_i);
         default: logic_r = '0;
      endcase
   end

   always_comb begin
      shift_r = '0;
      unique case (op_i)
         OP_SLL:  shift_r = r0_i << shamt;
         OP_SRL:  shift_r = r0_i >> shamt;
         OP_SRA:  shift_r = $signed(r0_i) >>> shamt;
         default: shift_r = '0;
      endcase
   end

   always_comb begin
      misc_r = '0;
      unique case (op_i)
         OP_LUI:    misc_r = upper;
         OP_PCADDU: misc_r = pc_i + upper;
         default:   misc_r = '0;
      endcase
   end

   always_comb begin
      res_o = '0;
      unique case (1'b1)
         (grand_op_i == GOP_ARITH): res_o = arith_r;
         (grand_op_i == GOP_LOGIC): res_o = logic_r;
         (grand_op_i == GOP_SHIFT): res_o = shift_r;
         (grand_op_i == GOP_MISC):  res_o = misc_r;
         default:                   res_o = '0;
      endcase
   end

endmodule

// File: rtl/e_alu_stage.sv
// Two-stage execute ALU: S1 holds the issued micro-op, S2 the result.
// Valid/ready on both sides; S2 contents are also offered as a bypass.
module e_alu_stage
   import e_alu_stage_pkg::*;
#(
   parameter int unsigned ROB_W  = 6,
   parameter int unsigned PREG_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [31:0]       req_r0_i,
   input  logic [31:0]       req_r1_i,
   input  logic [31:0]       req_pc_i,
   input  logic [2:0]        req_grand_op_i,
   input  logic [2:0]        req_op_i,
   input  logic [ROB_W-1:0]  req_rob_id_i,
   input  logic [PREG_W-1:0] req_preg_i,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [31:0]       wb_data_o,
   output logic [ROB_W-1:0]  wb_rob_id_o,
   output logic [PREG_W-1:0] wb_preg_o,
   output logic              fwd_valid_o,
   output logic [PREG_W-1:0] fwd_preg_o,
   output logic [31:0]       fwd_data_o,
   output logic [31:0]       perf_issue_cnt_o
);

   logic        s1_valid_q;
   logic        s1_valid_d;
   logic        s2_valid_q;
   logic        s2_valid_d;
   uop_t        s1_q;
   uop_t        s1_d;
   res_t        s2_q;
   res_t        s2_d;
   logic [31:0] perf_cnt_q;
   logic [31:0] perf_cnt_d;
   logic [31:0] alu_res;
   logic        s2_free;
   logic        s1_adv;
   logic        accept;

   assign s2_free     = !s2_valid_q || wb_ready_i;
   assign s1_adv      = s1_valid_q && s2_free;
   assign req_ready_o = !flush_i && (!s1_valid_q || s2_free);
   assign accept      = req_valid_i && req_ready_o;
   assign perf_cnt_d  = perf_cnt_q + 32'(accept);

   e_alu u_alu (
      .grand_op_i (s1_q.grand_op),
      .op_i       (s1_q.op),
      .r0_i       (s1_q.r0),
      .r1_i       (s1_q.r1),
      .pc_i       (s1_q.pc),
      .res_o      (alu_res)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (accept) begin
         s1_valid_d    = 1'b1;
         s1_d.r0       = req_r0_i;
         s1_d.r1       = req_r1_i;
         s1_d.pc       = req_pc_i;
         s1_d.grand_op = req_grand_op_i;
         s1_d.op       = req_op_i;
         s1_d.rob_id   = TAG_W'(req_rob_id_i);
         s1_d.preg     = TAG_W'(req_preg_i);
      end
      if (flush_i) begin
         s1_valid_d = 1'b0;
      end
   end

   // a drain and an S1 advance in the same cycle refill S2 with no bubble
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (wb_ready_i) begin
         s2_valid_d = 1'b0;
      end
      if (s1_adv) begin
         s2_valid_d  = 1'b1;
         s2_d.data   = alu_res;
         s2_d.rob_id = s1_q.rob_id;
         s2_d.preg   = s1_q.preg;
      end
      if (flush_i) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         perf_cnt_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         perf_cnt_q <= perf_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   assign wb_valid_o       = s2_valid_q;
   assign wb_data_o        = s2_q.data;
   assign wb_rob_id_o      = s2_q.rob_id[ROB_W-1:0];
   assign wb_preg_o        = s2_q.preg[PREG_W-1:0];
   assign fwd_valid_o      = s2_valid_q;
   assign fwd_preg_o       = s2_q.preg[PREG_W-1:0];
   assign fwd_data_o       = s2_q.data;
   assign perf_issue_cnt_o = perf_cnt_q;

   logic unused_tag_bits;
   assign unused_tag_bits = ^{s2_q.rob_id[TAG_W-1:ROB_W],
                              s2_q.preg[TAG_W-1:PREG_W]};

endmodule
